mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 31 +++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response and byte-wide memory bus of the memory access controller.
// The controller connects through the slave modport; the CPU/memory environment uses master.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              misaligned;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata,
    output busy, done, misaligned, rdata, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata,
    input  busy, done, misaligned, rdata, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Splits byte/halfword/word CPU loads and stores into little-endian byte transfers
// on a byte-wide memory, with alignment checking and load sign extension.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        k;
  logic [1:0]        k_next;
  logic [1:0]        last_k;
  logic              we_q;
  logic              sext_q;
  logic              misal_q;
  logic              misal_in;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_next;
  logic [31:0]       load_val;
  logic [31:0]       rdata_q;
  logic [7:0]        mem_wdata_q;

  always_comb begin
    misal_in = 1'b0;
    case (bus.size)
      2'b00:   misal_in = 1'b0;
      2'b01:   misal_in = bus.addr[0];
      default: misal_in = (bus.addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    last_k = 2'd3;
    case (size_q)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  assign k_next = k + 2'd1;

  // Load result includes the byte arriving in the final XFER cycle, so rdata is ready in DONE.
  always_comb begin
    asm_next = asm_q;
    asm_next[{k, 3'b000} +: 8] = bus.mem_rdata;
    load_val = asm_next;
    case (size_q)
      2'b00:   load_val = {{24{sext_q & asm_next[7]}},  asm_next[7:0]};
      2'b01:   load_val = {{16{sext_q & asm_next[15]}}, asm_next[15:0]};
      default: load_val = asm_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= 2'd0;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      misal_q     <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            sext_q  <= bus.sign_ext;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            misal_q <= misal_in;
            k       <= 2'd0;
            if (misal_in) begin
              state <= DONE;
              if (!bus.we) rdata_q <= 32'd0;
            end else begin
              state      <= XFER;
              mem_addr_q <= bus.addr;
              if (bus.we) mem_wdata_q <= bus.wdata[7:0];
            end
          end
        end
        XFER: begin
          if (!we_q) asm_q <= asm_next;
          if (k == last_k) begin
            state <= DONE;
            if (!we_q) rdata_q <= load_val;
          end else begin
            k          <= k_next;
            mem_addr_q <= addr_q + ADDR_W'(k_next);
            if (we_q) mem_wdata_q <= wdata_q[{k_next, 3'b000} +: 8];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.misaligned = (state == DONE) & misal_q;
  assign bus.mem_we     = (state == XFER) & we_q;
  assign bus.mem_re     = (state == XFER) & ~we_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide memory model and hand-computed expectations.
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic doneSeen;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr[11:0]];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request; after return the bench sits in cycle T+1 with inputs scrambled.
  task automatic applyStimulus(input logic iwe, input logic [1:0] isize, input logic isext,
                               input logic [31:0] iaddr, input logic [31:0] iwdata);
    bus.we       = iwe;
    bus.size     = isize;
    bus.sign_ext = isext;
    bus.addr     = iaddr;
    bus.wdata    = iwdata;
    bus.req      = 1'b1;
    step();
    bus.req      = 1'b0;
    bus.we       = ~iwe;
    bus.size     = ~isize;
    bus.sign_ext = ~isext;
    bus.addr     = 32'h0000_0F3C;
    bus.wdata    = 32'h5A5A_A5A5;
  endtask

  task automatic waitDone(input string tag, input int expSteps);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(n), 32'(expSteps));
  endtask

  initial begin
    logic [7:0] wordBytes [4];
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;

    step();
    step();
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_strobes", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    rst_n = 1'b1;
    step();

    // Word store: EF, BE, AD, DE to 0x100..0x103.
    wordBytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sw_we", {30'd0, bus.mem_we, bus.mem_re}, 32'd2);
      checkOutput("sw_addr", bus.mem_addr, 32'h100 + 32'(i));
      checkOutput("sw_wdata", {24'd0, bus.mem_wdata}, {24'd0, wordBytes[i]});
      checkOutput("sw_nodone", {31'd0, bus.done}, 32'd0);
      step();
    end
    checkOutput("sw_done", {29'd0, bus.done, bus.misaligned, bus.mem_we}, 32'd4);
    checkOutput("sw_hold_addr", bus.mem_addr, 32'h103);
    checkOutput("sw_hold_wdata", {24'd0, bus.mem_wdata}, 32'hDE);
    step();
    checkOutput("sw_idle", {31'd0, bus.busy}, 32'd0);
    checkOutput("sw_mem", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEADBEEF);

    // Byte store 0x80 at 0x101, then word 0x11223344 at 0x104.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345680);
    checkOutput("sb_wdata", {24'd0, bus.mem_wdata}, 32'h80);
    waitDone("sb_lat", 1);
    step();
    checkOutput("sb_mem", {24'd0, mem[12'h101]}, 32'h80);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344);
    waitDone("sw2_lat", 4);
    step();

    // Signed and unsigned byte loads of 0x80.
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
    checkOutput("lb_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd1);
    checkOutput("lb_addr", bus.mem_addr, 32'h101);
    waitDone("lb_lat", 1);
    checkOutput("lb_sext", bus.rdata, 32'hFFFFFF80);
    step();
    checkOutput("lb_hold", bus.rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    waitDone("lbu_lat", 1);
    checkOutput("lbu_zext", bus.rdata, 32'h00000080);
    step();

    // Halfword store 0x9234 at 0x200 and signed halfword load.
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h200, 32'hAAAA9234);
    waitDone("sh_lat", 2);
    step();
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h200, 32'h0);
    waitDone("lh_lat", 2);
    checkOutput("lh_sext", bus.rdata, 32'hFFFF9234);
    step();

    // Misaligned word store: no strobe, memory and rdata untouched.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h102, 32'h01020304);
    checkOutput("msw_flags", {28'd0, bus.done, bus.misaligned, bus.mem_we, bus.mem_re}, 32'hC);
    checkOutput("msw_rdata", bus.rdata, 32'hFFFF9234);
    step();
    checkOutput("msw_idle", {30'd0, bus.busy, bus.misaligned}, 32'd0);
    checkOutput("msw_mem", {24'd0, mem[12'h102]}, 32'hAD);

    // Misaligned halfword load clears rdata.
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h201, 32'h0);
    checkOutput("mlh_flags", {27'd0, bus.busy, bus.done, bus.misaligned, bus.mem_we, bus.mem_re}, 32'h1C);
    checkOutput("mlh_rdata", bus.rdata, 32'h0);
    step();

    // Zero the word at 0x300 for the reset test.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h300, 32'h0);
    waitDone("sw0_lat", 4);
    step();

    // Back-to-back word loads with req held; addr changes mid-access.
    bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0; bus.addr = 32'h100; bus.req = 1'b1;
    step();
    checkOutput("b2b_first_addr", bus.mem_addr, 32'h100);
    bus.addr = 32'h104;
    step(); step(); step();
    checkOutput("b2b_late_addr", bus.mem_addr, 32'h103);
    step();
    checkOutput("b2b_done1", {31'd0, bus.done}, 32'd1);
    checkOutput("b2b_rdata1", bus.rdata, 32'hDEAD80EF);
    step();
    checkOutput("b2b_gap", {31'd0, bus.busy}, 32'd0);
    step();
    checkOutput("b2b_second", {30'd0, bus.busy, bus.mem_re}, 32'd3);
    checkOutput("b2b_second_addr", bus.mem_addr, 32'h104);
    bus.req = 1'b0;
    waitDone("b2b_lat2", 4);
    checkOutput("b2b_rdata2", bus.rdata, 32'h11223344);
    step();

    // A req pulse during XFER is dropped.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h108, 32'h55667788);
    step();
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.addr = 32'h10C; bus.wdata = 32'h99;
    step();
    bus.req = 1'b0;
    waitDone("drop_lat", 2);
    step();
    step();
    checkOutput("drop_idle", {31'd0, bus.busy}, 32'd0);
    checkOutput("drop_addr", bus.mem_addr, 32'h10B);

    // Reset in the second XFER cycle of a word store.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D);
    step();
    checkOutput("rstx_pre", {30'd0, bus.mem_we, bus.mem_re}, 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("rstx_async", {28'd0, bus.busy, bus.done, bus.mem_we, bus.mem_re}, 32'd0);
    checkOutput("rstx_bus", {bus.mem_addr[23:0], bus.mem_wdata}, 32'd0);
    checkOutput("rstx_rdata", bus.rdata, 32'd0);
    doneSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      doneSeen = doneSeen | bus.done;
    end
    rst_n = 1'b1;
    step();
    checkOutput("rstx_nodone", {31'd0, doneSeen}, 32'd0);
    checkOutput("rstx_mem", {16'd0, mem[12'h301], mem[12'h300]}, 32'h000D);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h301, 32'h5A);
    waitDone("rstx_after_lat", 1);
    step();
    checkOutput("rstx_after_mem", {24'd0, mem[12'h301]}, 32'h5A);

    // Byte store at the very top of the address space.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'hA5);
    checkOutput("top_addr", bus.mem_addr, 32'hFFFFFFFF);
    waitDone("top_lat", 1);
    step();
    checkOutput("top_mem", {24'd0, mem[12'hFFF]}, 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
